// File: rtl/gpio_responder.sv
// Memory-mapped GPIO peripheral on the data-port bus: OUT/DIR/IN/STATUS/MASK/POL registers, edge capture and a level irq.
// Optional per-pin input debouncer enabled by defining GPIO_DEBOUNCE_EN.
module gpio_responder #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [3:0]        we,
    input  logic [2:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  gpio
);

    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_MASK   = 3'd4;
    localparam logic [2:0] A_POL    = 3'd5;

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_DELAY = DEBOUNCE_CYCLES;
`else
    localparam int DB_DELAY = 0 * DEBOUNCE_CYCLES;
`endif
    // Edge capture stays off until pin levels present at reset have reached prev.
    localparam int ARM_CYCLES = SYNC_STAGES + DB_DELAY + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] out_q, dir_q, status_q, mask_q, pol_q;
    logic [WIDTH-1:0] in_q, prev_q, sync_out, hit, status_nxt;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] wmask, wd;
    logic [31:0]      wmask_full, rd_mux;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed, wr_en, rd_en;

    assign wr_en = sel && (we != 4'b0000);
    assign rd_en = sel && (we == 4'b0000);

    always_comb begin
        wmask_full = '0;
        for (int b = 0; b < 4; b++) begin
            wmask_full[8*b +: 8] = {8{we[b]}};
        end
    end

    assign wmask = wmask_full[WIDTH-1:0];
    assign wd    = wdata[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt [WIDTH];

    // Count cycles the synchronized level has differed from IN; any return to IN restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == in_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    in_q[i]   <= sync_out[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign in_q = sync_out;
`endif

    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));
    assign hit   = ~dir_q & (( pol_q & in_q & ~prev_q) | (~pol_q & ~in_q & prev_q)) & {WIDTH{armed}};

    // A new edge in the same cycle as a W1C clear keeps the bit set.
    always_comb begin
        status_nxt = status_q;
        if (wr_en && addr == A_STATUS) begin
            status_nxt = status_q & ~(wd & wmask);
        end
        status_nxt = status_nxt | hit;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_OUT:    rd_mux[WIDTH-1:0] = out_q;
            A_DIR:    rd_mux[WIDTH-1:0] = dir_q;
            A_IN:     rd_mux[WIDTH-1:0] = in_q;
            A_STATUS: rd_mux[WIDTH-1:0] = status_q;
            A_MASK:   rd_mux[WIDTH-1:0] = mask_q;
            A_POL:    rd_mux[WIDTH-1:0] = pol_q;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            dir_q    <= '0;
            status_q <= '0;
            mask_q   <= '0;
            pol_q    <= '1;
            prev_q   <= '0;
            arm_cnt  <= '0;
            rdata    <= '0;
            irq      <= 1'b0;
        end else begin
            prev_q   <= in_q;
            status_q <= status_nxt;
            irq      <= |(status_q & mask_q);
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (rd_en) begin
                rdata <= rd_mux;
            end
            if (wr_en) begin
                case (addr)
                    A_OUT:   out_q  <= (out_q  & ~wmask) | (wd & wmask);
                    A_DIR:   dir_q  <= (dir_q  & ~wmask) | (wd & wmask);
                    A_MASK:  mask_q <= (mask_q & ~wmask) | (wd & wmask);
                    A_POL:   pol_q  <= (pol_q  & ~wmask) | (wd & wmask);
                    default: ;
                endcase
            end
        end
    end

endmodule
